// File: rtl/s2d_pkg.sv
// s2d_pkg: shared state type and elaboration helpers for sparse2dense_gen
package s2d_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, SP_REQ, SP_WAIT, DN_REQ, DN_WAIT, DN_WR, FIN} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/s2d_mask_dec.sv
// s2d_mask_dec: registered one-hot bit mask, offset 0 selects the MSB
module s2d_mask_dec #(
    parameter int WORD_W = 64,
    parameter int OFF_W  = 6
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [OFF_W-1:0]  off,
    output logic [WORD_W-1:0] mask
);
    // WORD_W is a power of two, so WORD_W-1-off is simply ~off
    always_ff @(posedge clk) begin
        if (!rst_b) mask <= '0;
        else mask <= WORD_W'(1) << ~off;
    end
endmodule

// File: rtl/sparse2dense_gen.sv
// sparse2dense_gen: scatters WEIGHT sparse bit indices into a dense word-addressed RAM image
module sparse2dense_gen
    import s2d_pkg::*;
#(
    parameter int R         = 10163,
    parameter int WEIGHT    = 71,
    parameter int IDX_W     = 14,
    parameter int WORD_W    = 64,
    parameter int ADDR_W    = 8,
    parameter int SP_ADDR_W = 7,
    parameter int RD_LAT    = 2,
    parameter int CLEAR_EN  = 1,
    parameter int ACC_OR    = 0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [SP_ADDR_W-1:0] sp_addr,
    input  logic [IDX_W-1:0]     sp_din,
    output logic [ADDR_W-1:0]    dn_addr,
    output logic                 dn_we,
    output logic [WORD_W-1:0]    dn_dout,
    input  logic [WORD_W-1:0]    dn_din
);
    localparam int WORDS      = ceil_div(R, WORD_W);
    localparam int OFF_W      = clog2(WORD_W);
    localparam int WORD_IDX_W = IDX_W - OFF_W;

    state_t                state;
    logic [1:0]            lat;
    logic [OFF_W-1:0]      off;
    logic [WORD_W-1:0]     mask;
    logic [WORD_IDX_W-1:0] word;
    logic                  lat_end, last_k, clr_end;

    assign word    = sp_din[IDX_W-1:OFF_W];
    assign lat_end = lat == 2'(RD_LAT - 1);
    // sp_addr doubles as the entry counter; it only moves on entry to SP_REQ
    assign last_k  = sp_addr == SP_ADDR_W'(WEIGHT - 1);
    assign clr_end = dn_addr == ADDR_W'(WORDS - 1);

    s2d_mask_dec #(.WORD_W(WORD_W), .OFF_W(OFF_W)) u_mask (
        .clk   (clk),
        .rst_b (rst_b),
        .off   (off),
        .mask  (mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state   <= IDLE;
            lat     <= '0;
            off     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            sp_addr <= '0;
            dn_addr <= '0;
            dn_we   <= 1'b0;
            dn_dout <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    err  <= 1'b0;
                    if (CLEAR_EN != 0) begin
                        state   <= CLEAR;
                        dn_addr <= '0;
                        dn_dout <= '0;
                        dn_we   <= 1'b1;
                    end else begin
                        state   <= SP_REQ;
                        sp_addr <= '0;
                    end
                end
                CLEAR: if (clr_end) begin
                    state   <= SP_REQ;
                    sp_addr <= '0;
                    dn_we   <= 1'b0;
                end else dn_addr <= dn_addr + ADDR_W'(1);
                SP_REQ: begin
                    state <= SP_WAIT;
                    lat   <= '0;
                end
                SP_WAIT: if (!lat_end) lat <= lat + 2'd1;
                else if (int'(sp_din) >= R) begin
                    err <= 1'b1;
                    if (last_k) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= SP_REQ;
                        sp_addr <= sp_addr + SP_ADDR_W'(1);
                    end
                end else begin
                    state   <= DN_REQ;
                    dn_addr <= ADDR_W'(word);
                    off     <= sp_din[OFF_W-1:0];
                end
                DN_REQ: begin
                    state <= DN_WAIT;
                    lat   <= '0;
                end
                DN_WAIT: if (!lat_end) lat <= lat + 2'd1;
                else begin
                    state   <= DN_WR;
                    dn_we   <= 1'b1;
                    dn_dout <= ACC_OR != 0 ? dn_din | mask : dn_din ^ mask;
                end
                DN_WR: begin
                    dn_we <= 1'b0;
                    if (last_k) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= SP_REQ;
                        sp_addr <= sp_addr + SP_ADDR_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse2dense_gen.sv
// tb_sparse2dense_gen: scoreboard bench over three parameter sets against a bit-level polynomial model
module tb_sparse2dense_gen;
    typedef struct {
        int           addr;
        logic [255:0] data;
    } wr_t;

    logic clk = 1'b0;
    int checks = 0;
    int failures = 0;
    int fin_cnt = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int R         = g == 2 ? 300 : 10163;
        localparam int WEIGHT    = g == 2 ? 20 : 71;
        localparam int IDX_W     = g == 2 ? 9 : 14;
        localparam int WORD_W    = g == 0 ? 64 : g == 1 ? 32 : 8;
        localparam int ADDR_W    = g == 0 ? 8 : g == 1 ? 9 : 6;
        localparam int SP_ADDR_W = g == 2 ? 5 : 7;
        localparam int RD_LAT    = g == 0 ? 2 : g == 1 ? 1 : 3;
        localparam int CLEAR_EN  = g == 1 ? 0 : 1;
        localparam int ACC_OR    = g == 1 ? 1 : 0;
        localparam int WORDS     = (R + WORD_W - 1) / WORD_W;
        localparam int ABORT     = WEIGHT > 40 ? 40 : WEIGHT / 2;

        logic                 rst_b = 1'b0;
        logic                 start = 1'b0;
        logic                 pre_go = 1'b0;
        logic                 busy, done, err, dn_we;
        logic [SP_ADDR_W-1:0] sp_addr;
        logic [IDX_W-1:0]     sp_din;
        logic [ADDR_W-1:0]    dn_addr;
        logic [WORD_W-1:0]    dn_dout, dn_din;
        logic [IDX_W-1:0]     sp_mem [2**SP_ADDR_W];
        logic [WORD_W-1:0]    dn_mem [2**ADDR_W];
        logic [WORD_W-1:0]    pre_img [2**ADDR_W];
        logic [WORD_W-1:0]    exp_mem [2**ADDR_W];
        logic [IDX_W-1:0]     sp_pipe [RD_LAT];
        logic [WORD_W-1:0]    dn_pipe [RD_LAT];
        int                   ent [WEIGHT];
        wr_t                  wq [$];
        int                   lq [$];
        logic                 erq [$];

        sparse2dense_gen #(
            .R(R), .WEIGHT(WEIGHT), .IDX_W(IDX_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
            .SP_ADDR_W(SP_ADDR_W), .RD_LAT(RD_LAT), .CLEAR_EN(CLEAR_EN), .ACC_OR(ACC_OR)
        ) dut (
            .clk(clk), .rst_b(rst_b), .start(start), .busy(busy), .done(done), .err(err),
            .sp_addr(sp_addr), .sp_din(sp_din), .dn_addr(dn_addr), .dn_we(dn_we),
            .dn_dout(dn_dout), .dn_din(dn_din)
        );

        // both RAMs: RD_LAT-deep read pipeline, dense RAM writes on dn_we
        always @(posedge clk) begin
            sp_pipe[0] <= sp_mem[sp_addr];
            dn_pipe[0] <= dn_mem[dn_addr];
            for (int i = 1; i < RD_LAT; i++) begin
                sp_pipe[i] <= sp_pipe[i-1];
                dn_pipe[i] <= dn_pipe[i-1];
            end
            if (pre_go) for (int i = 0; i < 2**ADDR_W; i++) dn_mem[i] <= pre_img[i];
            else if (dn_we) dn_mem[dn_addr] <= dn_dout;
        end
        assign sp_din = sp_pipe[RD_LAT-1];
        assign dn_din = dn_pipe[RD_LAT-1];

        function automatic string name(input string s);
            return $sformatf("c%0d_%s", g, s);
        endfunction

        function automatic int lat_of(input int n_ok, input int n_bad);
            return CLEAR_EN * WORDS + n_ok * (2 * RD_LAT + 3) + n_bad * (1 + RD_LAT);
        endfunction

        function automatic int rand_idx(input int i);
            int r = $urandom_range(15);
            if (r == 0) return R + $urandom_range(2**IDX_W - 1 - R);
            if (r < 3 && i > 0) return ent[i-1];
            return $urandom_range(R - 1);
        endfunction

        // polynomial bit p lives in word p/WORD_W at bit WORD_W-1-(p mod WORD_W)
        task automatic model(input int n, input bit push, output int n_ok, output int n_bad);
            n_ok = 0;
            n_bad = 0;
            if (CLEAR_EN != 0) for (int w = 0; w < WORDS; w++) begin
                exp_mem[w] = '0;
                if (push) wq.push_back('{w, 256'(0)});
            end
            for (int i = 0; i < n; i++) begin
                if (ent[i] >= R) n_bad++;
                else begin
                    int w = ent[i] / WORD_W;
                    int b = WORD_W - 1 - ent[i] % WORD_W;
                    exp_mem[w][b] = ACC_OR != 0 ? 1'b1 : ~exp_mem[w][b];
                    n_ok++;
                    if (push) wq.push_back('{w, 256'(exp_mem[w])});
                end
            end
        endtask

        task automatic prefill(input int mode);
            for (int i = 0; i < 2**ADDR_W; i++) begin
                pre_img[i] = mode == 0 ? '0 : mode == 1 ? '1 : WORD_W'({$urandom(), $urandom()});
                exp_mem[i] = pre_img[i];
            end
            @(negedge clk) pre_go = 1'b1;
            @(negedge clk) pre_go = 1'b0;
        endtask

        task automatic run(input int mode, input int abort_at, input bit pulse);
            int n_ok, n_bad, lim, bad;
            logic [WORD_W-1:0] snap [2**ADDR_W];
            prefill(mode);
            for (int i = 0; i < WEIGHT; i++) sp_mem[i] = IDX_W'(ent[i]);
            snap = exp_mem;
            model(WEIGHT, 1'b1, n_ok, n_bad);
            lim = lat_of(n_ok, n_bad);
            if (abort_at < 0) begin
                lq.push_back(lim);
                erq.push_back(n_bad != 0);
            end
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            if (abort_at >= 0) begin
                // land in the first DN_WAIT cycle of entry abort_at
                repeat (lat_of(abort_at, 0) + RD_LAT + 2) @(negedge clk);
                rst_b = 1'b0;
                @(negedge clk);
                check(name("abort_out"), {busy, done, err, dn_we, sp_addr, dn_addr, dn_dout}, '0);
                check(name("abort_pending"), wq.size(), n_ok - abort_at);
                rst_b = 1'b1;
                wq.delete();
                exp_mem = snap;
                model(abort_at, 1'b0, n_ok, n_bad);
            end else begin
                for (int j = 0; j < lim + 50 && !done; j++) begin
                    @(negedge clk);
                    start = pulse && (j == 10 || j == 30);
                end
                start = 1'b0;
                check(name("done_seen"), done, 1'b1);
            end
            repeat (2) @(negedge clk);
            bad = 0;
            for (int i = 0; i < 2**ADDR_W; i++) if (dn_mem[i] !== exp_mem[i]) bad++;
            check(name("image"), bad, 0);
        endtask

        initial begin
            int cyc = 0;
            int t0 = 0;
            logic pb = 1'b0;
            wr_t e;
            forever begin
                @(negedge clk);
                cyc++;
                if (busy && !pb) begin
                    t0 = cyc;
                    check(name("err_clr"), err, 1'b0);
                end
                pb = busy;
                if (dn_we) begin
                    check(name("wr_expected"), wq.size() > 0, 1'b1);
                    if (wq.size() > 0) begin
                        e = wq.pop_front();
                        check(name("wr_addr"), dn_addr, e.addr);
                        check(name("wr_data"), dn_dout, e.data);
                    end
                end
                if (done) begin
                    check(name("done_busy"), busy, 1'b0);
                    check(name("done_wq"), wq.size(), 0);
                    check(name("done_expected"), lq.size() > 0, 1'b1);
                    if (lq.size() > 0) begin
                        check(name("latency"), cyc - t0, lq.pop_front());
                        check(name("err"), err, erq.pop_front());
                    end
                end
            end
        end

        initial begin
            repeat (3) @(negedge clk);
            check(name("reset_out"), {busy, done, err, dn_we, sp_addr, dn_addr, dn_dout}, '0);
            rst_b = 1'b1;
            for (int i = 0; i < WEIGHT; i++) ent[i] = i;
            run(1, -1, 1'b0);
            for (int i = 0; i < WEIGHT; i++) ent[i] = R - 1;
            run(0, -1, 1'b1);
            for (int i = 0; i < WEIGHT; i++) ent[i] = i < 2 ? 5 : i - 2 < 5 ? i - 2 : i - 1;
            run(0, -1, 1'b0);
            for (int i = 0; i < WEIGHT; i++) ent[i] = i == 3 ? R : i == 9 ? 2**IDX_W - 1 : i * 97 % R;
            run(2, -1, 1'b0);
            for (int i = 0; i < WEIGHT; i++) ent[i] = $urandom_range(R - 1);
            run(2, ABORT, 1'b0);
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < WEIGHT; i++) ent[i] = rand_idx(i);
                run(2, -1, k[0]);
            end
            fin_cnt++;
        end
    end

    initial begin
        fork
            wait (fin_cnt == 3);
            #800_000;
        join_any
        check("all_cfg_done", fin_cnt, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
